// File: rtl/mips_seq_ctrl_pkg.sv
// Shared MIPS defines: opcode/funct constants, ALU op encodings,
// sequencer state encoding and trap cause encoding.
package mips_seq_ctrl_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_OTHER0 = 6'b000000;  // R-type, see funct
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;

  // R-type function codes (inst[5:0])
  localparam logic [5:0] OP0_ADD = 6'b100000;
  localparam logic [5:0] OP0_SUB = 6'b100010;
  localparam logic [5:0] OP0_AND = 6'b100100;
  localparam logic [5:0] OP0_OR  = 6'b100101;
  localparam logic [5:0] OP0_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  // Operand-2 source: register, sign-extended imm, zero-extended imm
  typedef enum logic [1:0] {
    SRC2_REG  = 2'd0,
    SRC2_SIMM = 2'd1,
    SRC2_ZIMM = 2'd2
  } src2_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_TRAP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } cause_e;

endpackage

// File: rtl/mips_decode.sv
// Combinational MIPS instruction decoder: opcode/funct to ALU controls,
// register write enable and illegal-instruction flag.
module mips_decode
  import mips_seq_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [2:0] o_alu_op,
  output logic [1:0] o_alu_src2,
  output logic       o_rd_src,
  output logic       o_writeenable,
  output logic       o_except
);

  // Decode table; unknown encodings raise except with all controls zero
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    o_alu_op      = '0;
    o_alu_src2    = '0;
    o_rd_src      = 1'b0;
    o_writeenable = 1'b0;
    o_except      = 1'b0;
    case (i_op)
      OP_OTHER0: begin
        o_alu_src2    = SRC2_REG;
        o_rd_src      = 1'b1;
        o_writeenable = 1'b1;
        case (i_funct)
          OP0_ADD: o_alu_op = ALU_ADD;
          OP0_SUB: o_alu_op = ALU_SUB;
          OP0_AND: o_alu_op = ALU_AND;
          OP0_OR:  o_alu_op = ALU_OR;
          OP0_SLT: o_alu_op = ALU_SLT;
          default: begin
            o_rd_src      = 1'b0;
            o_writeenable = 1'b0;
            o_except      = 1'b1;
          end
        endcase
      end
      OP_BEQ:  o_alu_op = ALU_SUB;
      OP_ADDI: begin
        o_alu_op      = ALU_ADD;
        o_alu_src2    = SRC2_SIMM;
        o_writeenable = 1'b1;
      end
      OP_ANDI: begin
        o_alu_op      = ALU_AND;
        o_alu_src2    = SRC2_ZIMM;
        o_writeenable = 1'b1;
      end
      OP_ORI: begin
        o_alu_op      = ALU_OR;
        o_alu_src2    = SRC2_ZIMM;
        o_writeenable = 1'b1;
      end
      default: o_except = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle MIPS sequencer: FETCH -> DECODE -> EXEC -> WB, with a
// sticky TRAP on illegal instruction or instruction-fetch timeout.
module mips_seq_ctrl
  import mips_seq_ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 255,
  parameter int RETIRE_W      = 32
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  input  logic                imem_ready,
  input  logic [31:0]         inst,
  output logic                pc_en,
  output logic                rf_wr_en,
  output logic [2:0]          alu_op,
  output logic [1:0]          alu_src2,
  output logic                rd_src,
  output logic                trapped,
  output logic [1:0]          trap_cause,
  output logic [RETIRE_W-1:0] retired
);

  localparam int            TO_W    = $clog2(FETCH_TIMEOUT + 1);
  // Count value during the last ready-less FETCH cycle allowed
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  state_e              r_state;
  state_e              w_next;
  logic [11:0]         r_ir;        // {opcode, funct}
  logic [TO_W-1:0]     r_to_cnt;
  logic [2:0]          r_alu_op;
  logic [1:0]          r_alu_src2;
  logic                r_rd_src;
  logic                r_we;
  cause_e              r_cause;
  logic [RETIRE_W-1:0] r_retired;

  logic [2:0]          w_dec_alu_op;
  logic [1:0]          w_dec_alu_src2;
  logic                w_dec_rd_src;
  logic                w_dec_we;
  logic                w_dec_except;
  logic                w_fetch_timeout;
  logic                w_inst_unused;

  // Only opcode and funct fields matter to the sequencer
  assign w_inst_unused = ^inst[25:6];

  mips_decode u_decode (
    .i_op          (r_ir[11:6]),
    .i_funct       (r_ir[5:0]),
    .o_alu_op      (w_dec_alu_op),
    .o_alu_src2    (w_dec_alu_src2),
    .o_rd_src      (w_dec_rd_src),
    .o_writeenable (w_dec_we),
    .o_except      (w_dec_except)
  );

  // A ready in the final allowed cycle wins over the timeout
  assign w_fetch_timeout = !imem_ready && (r_to_cnt == TO_LAST);

  // Next-state and per-state strobes
  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    pc_en    = 1'b0;
    rf_wr_en = 1'b0;
    trapped  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready)           w_next = ST_DECODE;
        else if (w_fetch_timeout) w_next = ST_TRAP;
      end
      ST_DECODE: w_next = w_dec_except ? ST_TRAP : ST_EXEC;
      ST_EXEC:   w_next = ST_WB;
      ST_WB: begin
        pc_en    = 1'b1;
        rf_wr_en = r_we;
        w_next   = ST_FETCH;
      end
      ST_TRAP: begin
        trapped = 1'b1;
        w_next  = ST_TRAP;
      end
      default: w_next = ST_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking (<=) so all registers update from pre-edge values.
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next;
  end

  // Instruction register, decoded controls, timeout counter, cause and retire count
  always_ff @(posedge clock) begin
    // NOTE: every control register is reset here because each one is visible on a port or steers sequencing.
    if (reset) begin
      r_ir       <= '0;
      r_to_cnt   <= '0;
      r_alu_op   <= '0;
      r_alu_src2 <= '0;
      r_rd_src   <= 1'b0;
      r_we       <= 1'b0;
      r_cause    <= CAUSE_NONE;
      r_retired  <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ready) begin
            r_ir     <= {inst[31:26], inst[5:0]};
            r_to_cnt <= '0;
          end else if (w_fetch_timeout) begin
            r_cause  <= CAUSE_TIMEOUT;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_DECODE: begin
          r_alu_op   <= w_dec_alu_op;
          r_alu_src2 <= w_dec_alu_src2;
          r_rd_src   <= w_dec_rd_src;
          r_we       <= w_dec_we;
          if (w_dec_except) r_cause <= CAUSE_ILLEGAL;
        end
        ST_WB: begin
          r_retired <= r_retired + RETIRE_W'(1);
          r_to_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign alu_op     = r_alu_op;
  assign alu_src2   = r_alu_src2;
  assign rd_src     = r_rd_src;
  assign trap_cause = r_cause;
  assign retired    = r_retired;

endmodule
